// File: rtl/rast_poly_fifo.sv
// rtl/rast_poly_fifo.sv - micropolygon elastic buffer between rasterizer stages
module rast_poly_fifo #(
    parameter int SIGFIG    = 24,
    parameter int VERTS     = 3,
    parameter int AXIS      = 3,
    parameter int COLORS    = 3,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    parameter int CNT_W     = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [VERTS*AXIS*SIGFIG-1:0]      in_poly,
    input  logic [COLORS*SIGFIG-1:0]          in_color,
    input  logic                              in_is_quad,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [VERTS*AXIS*SIGFIG-1:0]      out_poly,
    output logic [COLORS*SIGFIG-1:0]          out_color,
    output logic                              out_is_quad,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              almost_full,
    output logic [CNT_W-1:0]                  poly_cnt
);
    localparam int PW       = VERTS*AXIS*SIGFIG;
    localparam int CW       = COLORS*SIGFIG;
    localparam int EW       = PW + CW + 1;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH+1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] AF_CNT   = CNT_BITS'(DEPTH - AF_MARGIN);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("rast_poly_fifo: DEPTH must be at least 2");
        end
        if (AF_MARGIN < 0 || AF_MARGIN >= DEPTH) begin : g_bad_margin
            $error("rast_poly_fifo: AF_MARGIN must satisfy 0 <= AF_MARGIN < DEPTH");
        end
    endgenerate

    logic [EW-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                r_af;
    logic [CNT_W-1:0]    r_poly_cnt;
    logic [CNT_BITS-1:0] w_next_count;
    logic                w_push;
    logic                w_pop;
    logic [EW-1:0]       w_head;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = rst_n & ~flush & (r_count != FULL_CNT);
    assign out_valid = rst_n & ~flush & (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign out_poly    = w_head[EW-1 -: PW];
    assign out_color   = w_head[CW:1];
    assign out_is_quad = w_head[0];

    assign count       = r_count;
    assign almost_full = r_af;
    assign poly_cnt    = r_poly_cnt;

    always_comb begin
        w_next_count = r_count;
        if (w_push && !w_pop) begin
            w_next_count = r_count + CNT_BITS'(1);
        end else if (w_pop && !w_push) begin
            w_next_count = r_count - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_af       <= 1'b0;
            r_poly_cnt <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_af     <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_af    <= (w_next_count >= AF_CNT);
            if (w_push) begin
                // Explicit wrap so non-power-of-2 depths work.
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
                if (r_poly_cnt != '1) begin
                    r_poly_cnt <= r_poly_cnt + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_poly, in_color, in_is_quad};
        end
    end
endmodule

// File: tb/tb_rast_poly_fifo.sv
// tb/tb_rast_poly_fifo.sv - scoreboard bench for rast_poly_fifo at depths 4 and 3
module tb_rast_poly_fifo;
    localparam int SIGFIG = 8;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int CNT_W  = 3;
    localparam int AFM    = 1;
    localparam int PW     = VERTS*AXIS*SIGFIG;
    localparam int CW     = COLORS*SIGFIG;
    localparam int EW     = PW + CW + 1;
    localparam int D0     = 4;
    localparam int D1     = 3;
    localparam int PC_MAX = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [EW-1:0] in_bus = '0;

    logic             in_ready0, out_valid0, out_quad0, af0;
    logic [PW-1:0]    out_poly0;
    logic [CW-1:0]    out_color0;
    logic [2:0]       count0;
    logic [CNT_W-1:0] pc0;
    logic             in_ready1, out_valid1, out_quad1, af1;
    logic [PW-1:0]    out_poly1;
    logic [CW-1:0]    out_color1;
    logic [1:0]       count1;
    logic [CNT_W-1:0] pc1;

    rast_poly_fifo #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                     .DEPTH(D0), .AF_MARGIN(AFM), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_poly(in_bus[EW-1 -: PW]), .in_color(in_bus[CW:1]), .in_is_quad(in_bus[0]),
        .out_valid(out_valid0), .out_ready(out_ready), .out_poly(out_poly0),
        .out_color(out_color0), .out_is_quad(out_quad0), .count(count0),
        .almost_full(af0), .poly_cnt(pc0));

    rast_poly_fifo #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                     .DEPTH(D1), .AF_MARGIN(AFM), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_poly(in_bus[EW-1 -: PW]), .in_color(in_bus[CW:1]), .in_is_quad(in_bus[0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_poly(out_poly1),
        .out_color(out_color1), .out_is_quad(out_quad1), .count(count1),
        .almost_full(af1), .poly_cnt(pc1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    logic [EW-1:0]    w_out [2];
    logic [2:0]       w_cnt [2];
    logic             w_ir  [2];
    logic             w_ov  [2];
    logic             w_af  [2];
    logic [CNT_W-1:0] w_pc  [2];
    assign w_out[0] = {out_poly0, out_color0, out_quad0};
    assign w_out[1] = {out_poly1, out_color1, out_quad1};
    assign w_cnt[0] = count0;
    assign w_cnt[1] = {1'b0, count1};
    assign w_ir[0]  = in_ready0;
    assign w_ir[1]  = in_ready1;
    assign w_ov[0]  = out_valid0;
    assign w_ov[1]  = out_valid1;
    assign w_af[0]  = af0;
    assign w_af[1]  = af1;
    assign w_pc[0]  = pc0;
    assign w_pc[1]  = pc1;

    int            m_cnt [2] = '{0, 0};
    int            m_pc  [2] = '{0, 0};
    bit            m_af  [2] = '{1'b0, 1'b0};
    int            pops  [2] = '{0, 0};
    logic [EW-1:0] sb0 [$];
    logic [EW-1:0] sb1 [$];

    // Reference model + scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit            e_ir, e_ov, push, pop;
            logic [EW-1:0] e;
            e_ir = rst_n && !flush && (m_cnt[k] != dep(k));
            e_ov = rst_n && !flush && (m_cnt[k] != 0);
            check_eq($sformatf("u%0d.in_ready", k), w_ir[k], e_ir);
            check_eq($sformatf("u%0d.out_valid", k), w_ov[k], e_ov);
            check_eq($sformatf("u%0d.count", k), w_cnt[k], m_cnt[k]);
            check_eq($sformatf("u%0d.almost_full", k), w_af[k], m_af[k]);
            check_eq($sformatf("u%0d.poly_cnt", k), w_pc[k], m_pc[k]);
            push = e_ir && in_valid;
            pop  = e_ov && out_ready;
            if (pop) begin
                pops[k]++;
                if (((k == 0) ? sb0.size() : sb1.size()) == 0) begin
                    check_eq($sformatf("u%0d.sb_underflow", k), 1, 0);
                end else begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    check_eq($sformatf("u%0d.head_data", k), w_out[k], e);
                end
            end
            if (push) begin
                if (k == 0) sb0.push_back(in_bus);
                else        sb1.push_back(in_bus);
            end
            if (!rst_n || flush) begin
                m_cnt[k] = 0;
                m_af[k]  = 1'b0;
                if (!rst_n) m_pc[k] = 0;
                if (k == 0) sb0.delete();
                else        sb1.delete();
            end else begin
                m_cnt[k] = m_cnt[k] + int'(push) - int'(pop);
                if (push && m_pc[k] < PC_MAX) m_pc[k]++;
                m_af[k] = (m_cnt[k] >= dep(k) - AFM);
            end
        end
    end

    task automatic step(output bit a0, output bit a1);
        @(negedge clk);
        a0 = in_valid & in_ready0;
        a1 = in_valid & in_ready1;
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        in_bus = EW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a0, a1;
        int acc, p0;

        // Reset held with in_valid high
        in_valid = 1'b1; out_ready = 1'b1; new_data();
        repeat (3) step(a0, a1);
        check_eq("t1.in_ready", in_ready0, 0);
        check_eq("t1.out_valid", out_valid0, 0);
        check_eq("t1.count", count0, 0);
        check_eq("t1.poly_cnt", pc0, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step(a0, a1);

        // Fill / drain on depth 4
        out_ready = 1'b0; in_valid = 1'b1; new_data(); acc = 0;
        for (int i = 0; i < 8 && acc < 4; i++) begin
            step(a0, a1);
            if (a0) begin
                acc++;
                new_data();
                if (acc == 2) check_eq("t2.af_at2", af0, 0);
                if (acc == 3) check_eq("t2.af_at3", af0, 1);
            end
        end
        check_eq("t2.accepted", acc, 4);
        check_eq("t2.count_full", count0, 4);
        check_eq("t2.in_ready_full", in_ready0, 0);
        check_eq("t2.af_full", af0, 1);
        step(a0, a1);
        check_eq("t2.e_held", a0, 0);
        out_ready = 1'b1;
        step(a0, a1);
        check_eq("t2.no_push_full_pop", a0, 0);
        check_eq("t2.count_after_pop", count0, 3);
        out_ready = 1'b0;
        step(a0, a1);
        check_eq("t2.e_accepted", a0, 1);
        check_eq("t2.count_refill", count0, 4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step(a0, a1);
        check_eq("t2.drained", count0, 0);

        // Streaming
        in_valid = 1'b1; out_ready = 1'b1; new_data(); p0 = pops[0];
        for (int i = 0; i < 20; i++) begin
            step(a0, a1);
            if (a0) new_data();
            if (i == 1 || i == 10 || i == 19) check_eq("t3.count_steady", count0, 1);
        end
        check_eq("t3.pops", pops[0] - p0, 19);
        in_valid = 1'b0;
        repeat (4) step(a0, a1);

        // Wrap on depth 3 with random stalls
        acc = 0;
        new_data();
        for (int i = 0; i < 60; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            step(a0, a1);
            if (a1) begin
                acc++;
                new_data();
            end
        end
        check_eq("t4.enough_pushes", acc >= 10, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step(a0, a1);
        check_eq("t4.sb_empty", sb1.size(), 0);
        check_eq("t4.count", count1, 0);

        // Flush with a push attempt
        rst_n = 1'b0; step(a0, a1); rst_n = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1;
        new_data(); step(a0, a1);
        new_data(); step(a0, a1);
        check_eq("t5.count_pre", count0, 2);
        check_eq("t5.pc_pre", pc0, 2);
        flush = 1'b1; new_data();
        @(negedge clk);
        check_eq("t5.in_ready_flush", in_ready0, 0);
        check_eq("t5.out_valid_flush", out_valid0, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("t5.count_post", count0, 0);
        check_eq("t5.out_valid_post", out_valid0, 0);
        check_eq("t5.pc_post", pc0, 2);

        // Saturation and mid-stream reset
        rst_n = 1'b0; step(a0, a1); rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; acc = 0; new_data();
        for (int i = 0; i < 20 && acc < 9; i++) begin
            step(a0, a1);
            if (a0) begin
                acc++;
                new_data();
            end
        end
        check_eq("t6.pushes", acc, 9);
        check_eq("t6.pc_sat", pc0, 7);
        repeat (3) step(a0, a1);
        check_eq("t6.pc_hold", pc0, 7);
        out_ready = 1'b0;
        repeat (2) step(a0, a1);
        check_eq("t6.nonempty", count0 != 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6.in_ready_rst", in_ready0, 0);
        check_eq("t6.out_valid_rst", out_valid0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        check_eq("t6.count_rst", count0, 0);
        check_eq("t6.pc_rst", pc0, 0);
        check_eq("t6.af_rst", af0, 0);
        check_eq("t6.out_valid_post", out_valid0, 0);
        repeat (2) step(a0, a1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
